// File: rtl/frame_fetch_if.sv
// frame_fetch_if: vsync, data-memory read port, shadow-buffer write port and cpu status signals
interface frame_fetch_if #(
    parameter int DATA_WIDTH = 13
);
    logic                  vsync;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_din;
    logic                  buf_we;
    logic [DATA_WIDTH-1:0] buf_addr;
    logic [15:0]           buf_dout;
    logic                  resume;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  vsync, mem_din,
        output mem_addr, buf_we, buf_addr, buf_dout, resume, busy, overrun
    );

    modport slave (
        output vsync, mem_din,
        input  mem_addr, buf_we, buf_addr, buf_dout, resume, busy, overrun
    );
endinterface

// File: rtl/frame_fetch.sv
// frame_fetch: copies COUNT data-memory words into the shadow buffer on each vsync, then pulses resume
module frame_fetch #(
    parameter int DATA_WIDTH = 13,
    parameter int BASE_ADDR  = 0,
    parameter int COUNT      = 320
) (
    input logic           clk,
    input logic           reset,
    frame_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESUME} state_t;

    localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] LAST = DATA_WIDTH'(COUNT - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] idx;

    // Memory data arrives one cycle after its address, which is exactly when buf_we is up, so it passes straight through.
    assign bus.buf_dout = bus.buf_we ? bus.mem_din : '0;

    // Copy sequencer: address issue, write strobe one cycle behind, resume pulse, sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            bus.mem_addr <= BASE;
            bus.buf_we   <= 1'b0;
            bus.buf_addr <= '0;
            bus.resume   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (bus.vsync && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.vsync) begin
                        state        <= READ;
                        idx          <= '0;
                        bus.mem_addr <= BASE;
                        bus.busy     <= 1'b1;
                    end
                end
                READ: begin
                    bus.buf_we   <= 1'b1;
                    bus.buf_addr <= idx;
                    if (idx == LAST) begin
                        state        <= DRAIN;
                        bus.mem_addr <= BASE;
                    end else begin
                        idx          <= idx + 1'b1;
                        bus.mem_addr <= BASE + idx + 1'b1;
                    end
                end
                DRAIN: begin
                    bus.buf_we <= 1'b0;
                    bus.resume <= 1'b1;
                    state      <= RESUME;
                end
                default: begin
                    bus.resume <= 1'b0;
                    bus.busy   <= 1'b0;
                    idx        <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // The copy window must fit in the address space without wrapping.
    always_ff @(posedge clk)
        assert (COUNT >= 1 && BASE_ADDR + COUNT <= (1 << DATA_WIDTH))
        else $error("frame_fetch: BASE_ADDR+COUNT exceeds the address space");
endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: scoreboard bench for frame_fetch in three configurations
module tb_frame_fetch;
    localparam int DW = 13;

    typedef struct {
        int             cyc;
        logic [DW-1:0]  addr;
        logic [15:0]    data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          pc;
    wr_t         wq[$];
    int          rq[$];
    logic [15:0] shadow [0:511];

    frame_fetch_if #(.DATA_WIDTH(DW)) a_if ();
    frame_fetch_if #(.DATA_WIDTH(DW)) b_if ();
    frame_fetch_if #(.DATA_WIDTH(DW)) c_if ();

    frame_fetch #(.DATA_WIDTH(DW), .BASE_ADDR(16), .COUNT(4)) dut_a (.clk(clk), .reset(reset), .bus(a_if.master));
    frame_fetch #(.DATA_WIDTH(DW), .BASE_ADDR(5), .COUNT(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if.master));
    frame_fetch #(.DATA_WIDTH(DW)) dut_c (.clk(clk), .reset(reset), .bus(c_if.master));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_val(input logic [DW-1:0] a);
        logic [15:0] w;
        w = 16'(a);
        return (w * 16'h9e37) ^ 16'h1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input int e);
        for (int k = 0; k < 4; k++) wq.push_back('{e + 1 + k, DW'(k), mem_val(DW'(16 + k))});
        rq.push_back(e + 5);
    endtask

    task automatic pulse_a(output int e);
        @(negedge clk);
        a_if.vsync = 1'b1;
        e = cyc + 1;
        expect_frame(e);
        @(negedge clk);
        a_if.vsync = 1'b0;
    endtask

    // Synchronous RAMs and the shadow buffer of the full-size instance
    always @(posedge clk) begin
        a_if.mem_din <= mem_val(a_if.mem_addr);
        b_if.mem_din <= (b_if.mem_addr == DW'(5)) ? 16'h1234 : 16'hdead;
        c_if.mem_din <= mem_val(c_if.mem_addr);
        if (c_if.buf_we) shadow[c_if.buf_addr[8:0]] <= c_if.buf_dout;
    end

    // cpu model: pc 8 is a WAIT that holds until the resume pulse
    always @(posedge clk or posedge reset)
        if (reset) pc <= 0;
        else if (pc != 8 || c_if.resume) pc <= pc + 1;

    // Scoreboard consumer for instance a
    always @(negedge clk) begin
        if (!reset) begin
            if (a_if.buf_we) begin
                if (wq.size() == 0) check("a_spurious_we", 1'b1, 1'b0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("a_wr_cyc", cyc, w.cyc);
                    check("a_wr_addr", a_if.buf_addr, w.addr);
                    check("a_wr_data", a_if.buf_dout, w.data);
                end
            end
            if (a_if.resume) begin
                if (rq.size() == 0) check("a_spurious_resume", 1'b1, 1'b0);
                else check("a_resume_cyc", cyc, rq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int e, n;
        bit frozen;
        a_if.vsync = 1'b0;
        b_if.vsync = 1'b0;
        c_if.vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_addr", a_if.mem_addr, 16);
        check("rst_buf_we", a_if.buf_we, 1'b0);
        check("rst_buf_addr", a_if.buf_addr, 0);
        check("rst_buf_dout", a_if.buf_dout, 0);
        check("rst_resume", a_if.resume, 1'b0);
        check("rst_busy", a_if.busy, 1'b0);
        check("rst_overrun", a_if.overrun, 1'b0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        pulse_a(e);
        for (int j = 0; j < 6; j++) begin
            check("a_busy_copy", a_if.busy, 1'b1);
            @(negedge clk);
        end
        check("a_busy_idle", a_if.busy, 1'b0);
        check("a_overrun_clean", a_if.overrun, 1'b0);
        check("a_addr_idle", a_if.mem_addr, 16);
        pulse_a(e);
        repeat (2) @(negedge clk);
        a_if.vsync = 1'b1;
        @(negedge clk);
        a_if.vsync = 1'b0;
        check("a_overrun_set", a_if.overrun, 1'b1);
        repeat (4) @(negedge clk);
        check("a_busy_after_ovr", a_if.busy, 1'b0);
        check("a_overrun_sticky", a_if.overrun, 1'b1);
        pulse_a(e);
        @(negedge clk);
        #2 reset = 1'b1;
        wq.delete();
        rq.delete();
        #1;
        check("rst_mid_buf_we", a_if.buf_we, 1'b0);
        check("rst_mid_busy", a_if.busy, 1'b0);
        check("rst_mid_resume", a_if.resume, 1'b0);
        check("rst_mid_overrun", a_if.overrun, 1'b0);
        check("rst_mid_mem_addr", a_if.mem_addr, 16);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);
        pulse_a(e);
        repeat (7) @(negedge clk);
        check("a_busy_after_rst", a_if.busy, 1'b0);
        @(negedge clk);
        a_if.vsync = 1'b1;
        e = cyc + 1;
        expect_frame(e);
        expect_frame(e + 7);
        expect_frame(e + 14);
        repeat (20) @(negedge clk);
        a_if.vsync = 1'b0;
        repeat (4) @(negedge clk);
        check("a_busy_held", a_if.busy, 1'b0);
        check("a_overrun_held", a_if.overrun, 1'b1);
        @(negedge clk);
        b_if.vsync = 1'b1;
        @(negedge clk);
        b_if.vsync = 1'b0;
        check("b_busy", b_if.busy, 1'b1);
        check("b_we_early", b_if.buf_we, 1'b0);
        @(negedge clk);
        check("b_we", b_if.buf_we, 1'b1);
        check("b_addr", b_if.buf_addr, 0);
        check("b_data", b_if.buf_dout, 16'h1234);
        check("b_resume_early", b_if.resume, 1'b0);
        @(negedge clk);
        check("b_resume", b_if.resume, 1'b1);
        check("b_we_off", b_if.buf_we, 1'b0);
        @(negedge clk);
        check("b_resume_off", b_if.resume, 1'b0);
        check("b_busy_off", b_if.busy, 1'b0);
        check("b_addr_idle", b_if.mem_addr, 5);
        check("c_pc_wait", pc, 8);
        frozen = 1'b1;
        n = 0;
        @(negedge clk);
        c_if.vsync = 1'b1;
        @(negedge clk);
        c_if.vsync = 1'b0;
        while (!c_if.resume && n < 400) begin
            if (pc != 8) frozen = 1'b0;
            @(negedge clk);
            n++;
        end
        check("c_resume_seen", c_if.resume, 1'b1);
        check("c_latency", n, 321);
        check("c_pc_frozen", frozen, 1'b1);
        check("c_pc_at_resume", pc, 8);
        @(negedge clk);
        check("c_pc_advance", pc, 9);
        for (int k = 0; k < 320; k++) check("c_buf_word", shadow[k], mem_val(DW'(k)));
        repeat (2) @(negedge clk);
        check("a_writes_left", wq.size(), 0);
        check("a_resumes_left", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frame_fetch.md
FRAME_FETCH -- requirements
Module: frame_fetch

Interface
Parameters:
REQ-001 DATA_WIDTH, 13, data-memory address width in bits.
REQ-002 BASE_ADDR, 0, first data-memory word address copied each frame.
REQ-003 COUNT, 320, number of words copied per frame; legal range 1..2^DATA_WIDTH-BASE_ADDR.
Ports:
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high; forces reset state immediately, released synchronously to clk.
REQ-006 vsync  input  1  frame-start strobe; sampled high starts a copy.
REQ-007 mem_addr  output  DATA_WIDTH  data-memory read address, on the read port not used by the cpu.
REQ-008 mem_din  input  16  read data; valid the cycle after mem_addr is presented (synchronous RAM).
REQ-009 buf_we  output  1  shadow-buffer write enable.
REQ-010 buf_addr  output  DATA_WIDTH  shadow-buffer write index, 0..COUNT-1.
REQ-011 buf_dout  output  16  shadow-buffer write data.
REQ-012 resume  output  1  one-cycle pulse to cpu resume: frame copied, cpu may continue after WAIT.
REQ-013 busy  output  1  high while a copy is in progress.
REQ-014 overrun  output  1  sticky; set when vsync arrives while busy.

Function
REQ-015 States: IDLE, READ, DRAIN, RESUME; encoding is free.
REQ-016 IDLE: vsync=1 at a posedge -> READ, with read index i=0; otherwise stay.
REQ-017 READ: mem_addr = BASE_ADDR + i each cycle; i increments by 1 per cycle; when i = COUNT-1 has been issued -> DRAIN.
REQ-018 Data pipeline: in the cycle after address BASE_ADDR+k is issued, buf_we=1, buf_addr=k, buf_dout=mem_din.
REQ-019 DRAIN: one cycle; writes the last word (k=COUNT-1); no new address is issued -> RESUME.
REQ-020 RESUME: resume=1 for exactly one cycle, buf_we=0 -> IDLE.
REQ-021 Latency: vsync sampled at edge E -> first buf_we in cycle E+2 -> last buf_we at E+COUNT+1 -> resume at E+COUNT+2; total COUNT+2 cycles busy.
REQ-022 busy=1 in READ, DRAIN, RESUME; 0 in IDLE.
REQ-023 Writes are strictly sequential 0..COUNT-1, with exactly COUNT buf_we pulses per frame, no gaps and no duplicates.
REQ-024 mem_addr holds BASE_ADDR in IDLE; buf_addr and buf_dout are don't-care when buf_we=0 but shall not be X after reset.
REQ-025 Address arithmetic uses DATA_WIDTH bits; BASE_ADDR+COUNT-1 shall not wrap (parameter violation is flagged by a simulation assertion).
REQ-026 vsync in READ/DRAIN/RESUME: ignored for sequencing; sets overrun=1; the current copy completes unchanged.
REQ-027 vsync high in the same cycle resume is driven: treated as overrun, not a new start.
REQ-028 vsync held high continuously: one copy per IDLE entry; a new copy restarts on the first IDLE cycle with vsync=1.
REQ-029 COUNT=1: READ lasts one cycle, DRAIN writes index 0, resume follows.
REQ-030 resume is never asserted without a complete COUNT-word copy preceding it.

Reset
REQ-031 Reset state: IDLE, i=0, mem_addr=BASE_ADDR, buf_we=0, buf_addr=0, buf_dout=0, resume=0, busy=0, overrun=0.
REQ-032 Reset asserted mid-copy: outputs take reset values asynchronously; no resume is issued for the aborted frame; a partial buffer is permitted.
REQ-033 First vsync after reset release starts a full copy from index 0.

Verification
REQ-034 BASE_ADDR=16, COUNT=4, mem[16..19]=A,B,C,D; vsync pulse at edge 10 -> buf writes (0,A)@12, (1,B)@13, (2,C)@14, (3,D)@15; resume@16 only; busy high 11..16.
REQ-035 Same config; second vsync at edge 13 -> overrun=1 from edge 14 onward; write sequence and resume@16 unchanged; no second copy starts.
REQ-036 Reset pulse at edge 13 during the copy -> buf_we, busy, resume=0 immediately; no resume observed; next vsync at edge 20 -> full copy, resume@26.
REQ-037 COUNT=1, mem[BASE]=0x1234; vsync@5 -> single write (0,0x1234)@7, resume@8.
REQ-038 vsync held high for 20 cycles, COUNT=4 -> copies start at edges 0, 7, 14; resume at 6, 13, 20; overrun set.
REQ-039 Full default config (COUNT=320) against a cpu model that executes WAIT -> cpu pc frozen until the resume pulse, then advances; buffer matches memory word-for-word.
